// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// register-index constants and the packed control-output bundle.
package hazard_stall_ctrl_pkg;

   localparam int REG_W  = 5;
   localparam int WAIT_W = 8;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } fsm_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_hold;
      logic memwb_flush;
   } ctrl_t;

   // Field order: pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_flush
   localparam ctrl_t CTRL_DEFAULT = ctrl_t'(6'b110000);
   localparam ctrl_t CTRL_RESET   = ctrl_t'(6'b001101);
   localparam ctrl_t CTRL_MEMWAIT = ctrl_t'(6'b000011);
   localparam ctrl_t CTRL_BRANCH  = ctrl_t'(6'b111100);
   localparam ctrl_t CTRL_LOADUSE = ctrl_t'(6'b000100);
   localparam ctrl_t CTRL_JUMP    = ctrl_t'(6'b101000);

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the
// instruction in ID. Writes to the zero register never create a hazard.
module load_use_detect
   import hazard_stall_ctrl_pkg::*;
(
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rt,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   output logic             hazard
);

   always_comb begin
      hazard = ex_memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (ex_rt == id_rt));
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush sequencer: memory wait FSM with watchdog, priority mux
// over memory wait / branch / load-use / jump, and a stall-cycle counter.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rt,
   input  logic             EX_BranchTaken,
   input  logic             MEM_req,
   input  logic             MEM_ready,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             EXMEM_Hold,
   output logic             MEMWB_Flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   fsm_e              fsm_q, fsm_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
   logic              load_use;
   logic              mem_wait;
   ctrl_t             ctrl;

   load_use_detect u_load_use_detect (
      .ex_memread (EX_MemRead),
      .ex_rt      (EX_rt),
      .id_rs      (ID_rs),
      .id_rt      (ID_rt),
      .hazard     (load_use)
   );

   // A ready cycle in MEMWAIT is the release cycle, not a wait cycle.
   always_comb begin
      mem_wait = !MEM_ready && ((fsm_q == MEMWAIT) || MEM_req);
   end

   always_comb begin
      ctrl = CTRL_DEFAULT;
      if (reset)               ctrl = CTRL_RESET;
      else if (mem_wait)       ctrl = CTRL_MEMWAIT;
      else if (EX_BranchTaken) ctrl = CTRL_BRANCH;
      else if (load_use)       ctrl = CTRL_LOADUSE;
      else if (ID_Jump)        ctrl = CTRL_JUMP;
   end

   always_comb begin
      fsm_d          = mem_wait ? MEMWAIT : RUN;
      wait_cnt_d     = '0;
      mem_timeout_d  = mem_timeout_q;
      stall_cycles_d = stall_cycles_q;
      if (mem_wait) begin
         wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
         if (int'(wait_cnt_d) >= MEM_TIMEOUT)
            mem_timeout_d = 1'b1;
      end
      if (!ctrl.pc_write && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q          <= RUN;
         wait_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         fsm_q          <= fsm_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign PCWrite      = ctrl.pc_write;
   assign IFID_Write   = ctrl.ifid_write;
   assign IFID_Flush   = ctrl.ifid_flush;
   assign IDEX_Flush   = ctrl.idex_flush;
   assign EXMEM_Hold   = ctrl.exmem_hold;
   assign MEMWB_Flush  = ctrl.memwb_flush;
   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: the stimulus process pushes hand-computed expectations per
// cycle; a negedge monitor pops and compares against the live outputs.
module tb_hazard_stall_ctrl;

   localparam int CNT_W = 3;
   localparam int SAT   = 7;

   localparam logic [5:0] DEF = 6'b110000;
   localparam logic [5:0] RST = 6'b001101;
   localparam logic [5:0] WT  = 6'b000011;
   localparam logic [5:0] BR  = 6'b111100;
   localparam logic [5:0] LU  = 6'b000100;
   localparam logic [5:0] JMP = 6'b101000;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [4:0]       ID_rs = '0, ID_rt = '0, EX_rt = '0;
   logic             ID_Jump = 1'b0, EX_MemRead = 1'b0, EX_BranchTaken = 1'b0;
   logic             MEM_req = 1'b0, MEM_ready = 1'b0;
   logic             PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Hold, MEMWB_Flush;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cycles;

   hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_Jump(ID_Jump),
      .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .EX_BranchTaken(EX_BranchTaken),
      .MEM_req(MEM_req), .MEM_ready(MEM_ready), .PCWrite(PCWrite),
      .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
      .EXMEM_Hold(EXMEM_Hold), .MEMWB_Flush(MEMWB_Flush),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [5:0] ctrl;
      int         sc;
      int         to;   // -1: not checked this cycle
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   int   exp_sc = 0;

   // r, req, rdy, br, memread, ex_rt, rs, rt, jump -> expected ctrl, timeout
   task automatic v(input string nm, input logic r, input logic rq, input logic rd,
                    input logic br, input logic mr, input logic [4:0] ert,
                    input logic [4:0] rs, input logic [4:0] rt, input logic j,
                    input logic [5:0] ec, input int eto);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r; MEM_req = rq; MEM_ready = rd; EX_BranchTaken = br;
      EX_MemRead = mr; EX_rt = ert; ID_rs = rs; ID_rt = rt; ID_Jump = j;
      e.name = nm; e.ctrl = ec; e.sc = exp_sc; e.to = eto;
      sb.push_back(e);
      if (r)           exp_sc = 0;
      else if (!ec[5]) exp_sc = (exp_sc >= SAT) ? SAT : exp_sc + 1;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [5:0] act;
         e = sb.pop_front();
         act = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Hold, MEMWB_Flush};
         checks++;
         if (act === e.ctrl) passes++;
         else $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
         checks++;
         if (stall_cycles === CNT_W'(e.sc)) passes++;
         else $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.sc);
         if (e.to >= 0) begin
            checks++;
            if (mem_timeout === e.to[0]) passes++;
            else $display("FAIL %s mem_timeout: got %b expected %0d", e.name, mem_timeout, e.to);
         end
      end
   end

   initial begin
      v("rst0",   1, 0,0,0,0,0,0,0,0, RST, 0);
      v("rst1",   1, 0,0,0,0,0,0,0,0, RST, 0);
      // load-use and its boundaries
      v("lu_rs",  0, 0,0,0,1,8,8,0,0, LU,  0);
      v("post_lu",0, 0,0,0,0,0,0,0,0, DEF, 0);
      v("lu_zero",0, 0,0,0,1,0,0,0,0, DEF, 0);
      v("lu_rt",  0, 0,0,0,1,9,3,9,0, LU,  0);
      v("no_match",0,0,0,0,1,9,3,4,0, DEF, 0);
      v("br_lu_j",0, 0,0,1,1,8,8,0,1, BR,  0);
      v("jump",   0, 0,0,0,0,0,0,0,1, JMP, 0);
      v("idle_a", 0, 0,0,0,0,0,0,0,0, DEF, 0);
      v("rst2",   1, 0,0,0,0,0,0,0,0, RST, 0);
      // memory wait
      v("zero_wait",0,1,1,0,0,0,0,0,0, DEF, 0);
      for (int i = 0; i < 3; i++) v("mem_wait", 0, 1,0,0,0,0,0,0,0, WT, 0);
      v("mem_rel",0, 1,1,0,0,0,0,0,0, DEF, 0);
      v("post_mw",0, 0,0,0,0,0,0,0,0, DEF, 0);
      for (int i = 0; i < 2; i++) v("jump_wait", 0, 1,0,0,0,0,0,0,1, WT, 0);
      v("jump_rel",0,1,1,0,0,0,0,0,1, JMP, 0);
      v("lu_wait",0, 1,0,0,1,8,8,0,0, WT,  0);
      v("lu_rel", 0, 1,1,0,1,8,8,0,0, LU,  0);
      v("idle_b", 0, 0,0,0,0,0,0,0,0, DEF, 0);
      v("rst3",   1, 0,0,0,0,0,0,0,0, RST, 0);
      // watchdog
      for (int i = 0; i < 4; i++) v("to_wait", 0, 1,0,0,0,0,0,0,0, WT, 0);
      for (int i = 0; i < 2; i++) v("to_wait_late", 0, 1,0,0,0,0,0,0,0, WT, -1);
      v("to_rel", 0, 1,1,0,0,0,0,0,0, DEF, 1);
      v("to_sticky",0,0,0,0,0,0,0,0,0, DEF, 1);
      v("to_rst", 1, 0,0,0,0,0,0,0,0, RST, 1);
      v("to_clr", 0, 0,0,0,0,0,0,0,0, DEF, 0);
      // reset in the middle of a wait
      for (int i = 0; i < 2; i++) v("mid_wait", 0, 1,0,0,0,0,0,0,0, WT, 0);
      v("mid_rst",0, 0,0,0,0,0,0,0,0, WT,  0);
      v("mid_rst",1, 1,0,0,0,0,0,0,0, RST, 0);
      v("after_rst",0,0,0,0,0,0,0,0,0, DEF, 0);
      // stall counter saturation
      for (int i = 0; i < 10; i++) v("sat_lu", 0, 0,0,0,1,5,0,5,0, LU, 0);
      v("sat_chk",0, 0,0,0,0,0,0,0,0, DEF, 0);
      @(negedge clk);
      #1;
      checks++;
      if (sb.size() == 0) passes++;
      else $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
